// File: rtl/mycpu_exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ALU, data-SRAM request, EXE->MEM register.
// Latency: one cycle from in_* to ex2mem_*; ALU, forwarding and SRAM request are combinational.
// Backpressure: exe_allowin mirrors mem_allowin; while MEM stalls the EXE->MEM register holds and no SRAM request is issued.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_*                ID->EXE pipeline-register bundle
//   exe_allowin         EXE can take a new bundle this cycle
//   mem_allowin         MEM accepts the EXE->MEM register this cycle
//   fwd_target/fwd_data "minus-1 instruction" hazard/forward feedback to decode
//   dsram_*             data-SRAM request (word-aligned address, lane-replicated data)
//   ex2mem_*            registered EXE->MEM pipeline register
//
// Optional feature: define MYCPU_EXE_OVF_TRAP_EN to make ops 1100/1101 detect signed
// overflow, suppress register write and forwarding on overflow, and add ex2mem_ovf.
module mycpu_exe_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_op1,
    input  logic [DW-1:0] in_op2,
    input  logic [DW-1:0] in_pc,
    input  logic [RW-1:0] in_target_reg,
    input  logic [DW-1:0] in_store_data,
    input  logic [3:0]    in_alu_op,
    input  logic          in_rf_wen,
    input  logic [5:0]    in_ls_mode,
    output logic          exe_allowin,
    input  logic          mem_allowin,
    output logic [RW:0]   fwd_target,
    output logic [DW-1:0] fwd_data,
    output logic          dsram_en,
    output logic [3:0]    dsram_wen,
    output logic [DW-1:0] dsram_addr,
    output logic [DW-1:0] dsram_wdata,
    output logic          ex2mem_valid,
    output logic [DW-1:0] ex2mem_result,
    output logic [DW-1:0] ex2mem_pc,
    output logic [RW-1:0] ex2mem_target_reg,
    output logic          ex2mem_rf_wen,
    output logic [5:0]    ex2mem_ls_mode,
`ifdef MYCPU_EXE_OVF_TRAP_EN
    output logic [1:0]    ex2mem_addr_lo,
    output logic          ex2mem_ovf
`else
    output logic [1:0]    ex2mem_addr_lo
`endif
);

    // Store size encodings in ls_mode[3:1]
    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;
    localparam logic [2:0] SZ_SWL  = 3'b011;
    localparam logic [2:0] SZ_SWR  = 3'b100;

    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] sum_ab;
    logic [DW-1:0] diff_ab;
    logic [4:0]    shamt;
    logic          ovf;
    logic          rf_wen_eff;
    logic          is_load;
    logic          is_store;
    logic [1:0]    addr_lo;

    assign alu_a   = in_op1;
    assign alu_b   = in_op2;
    assign sum_ab  = alu_a + alu_b;
    assign diff_ab = alu_a - alu_b;
    assign shamt   = alu_a[4:0];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    always_comb begin
        alu_result = '0;
        case (in_alu_op)
            4'b0000: alu_result = sum_ab;
            4'b0001: alu_result = diff_ab;
            4'b0010: alu_result = {{(DW-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            4'b0011: alu_result = {{(DW-1){1'b0}}, (alu_a < alu_b)};
            4'b0100: alu_result = alu_a & alu_b;
            4'b0101: alu_result = alu_a | alu_b;
            4'b0110: alu_result = alu_a ^ alu_b;
            4'b0111: alu_result = ~(alu_a | alu_b);
            4'b1000: alu_result = alu_b << shamt;
            4'b1010: alu_result = alu_b >> shamt;
            4'b1011: alu_result = $unsigned($signed(alu_b) >>> shamt);
            4'b1100: alu_result = sum_ab;
            4'b1101: alu_result = diff_ab;
            default: alu_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Signed overflow on the trapping add/sub ops
    // ------------------------------------------------------------------
`ifdef MYCPU_EXE_OVF_TRAP_EN
    always_comb begin
        ovf = 1'b0;
        if (in_alu_op == 4'b1100) begin
            ovf = (alu_a[DW-1] == alu_b[DW-1]) && (sum_ab[DW-1] != alu_a[DW-1]);
        end else if (in_alu_op == 4'b1101) begin
            ovf = (alu_a[DW-1] != alu_b[DW-1]) && (diff_ab[DW-1] != alu_a[DW-1]);
        end
    end
`else
    assign ovf = 1'b0;
`endif

    // An overflowing instruction must not reach the register file or be forwarded.
    assign rf_wen_eff = in_rf_wen & ~ovf;

    // ------------------------------------------------------------------
    // Forwarding to decode. r0 never forwards a value, so decode sees 0.
    // ------------------------------------------------------------------
    always_comb begin
        fwd_target = '0;
        fwd_data   = '0;
        if (in_valid && rf_wen_eff && (in_target_reg != '0)) begin
            fwd_target = {in_ls_mode[5], in_target_reg};
            fwd_data   = alu_result;
        end
    end

    // ------------------------------------------------------------------
    // Data-SRAM request
    // ------------------------------------------------------------------
    assign is_load     = in_ls_mode[5];
    assign is_store    = in_ls_mode[4];
    assign addr_lo     = alu_result[1:0];
    assign exe_allowin = mem_allowin;

    // Gating with mem_allowin makes the request fire exactly once: on the
    // cycle the instruction leaves EXE.
    assign dsram_en   = in_valid & mem_allowin & (is_load | is_store);
    assign dsram_addr = {alu_result[DW-1:2], 2'b00};

    always_comb begin
        dsram_wen   = 4'b0000;
        dsram_wdata = in_store_data;
        if (is_store) begin
            case (in_ls_mode[3:1])
                SZ_BYTE: begin
                    dsram_wen   = 4'b0001 << addr_lo;
                    dsram_wdata = {4{in_store_data[7:0]}};
                end
                SZ_HALF: begin
                    dsram_wen   = addr_lo[1] ? 4'b1100 : 4'b0011;
                    dsram_wdata = {2{in_store_data[15:0]}};
                end
                SZ_WORD: begin
                    dsram_wen   = 4'b1111;
                    dsram_wdata = in_store_data;
                end
                SZ_SWL: begin
                    // Upper bytes of the register land in the low lanes up to addr.
                    case (addr_lo)
                        2'd0:    dsram_wen = 4'b0001;
                        2'd1:    dsram_wen = 4'b0011;
                        2'd2:    dsram_wen = 4'b0111;
                        default: dsram_wen = 4'b1111;
                    endcase
                    dsram_wdata = in_store_data >> {(2'd3 - addr_lo), 3'b000};
                end
                SZ_SWR: begin
                    // Lower bytes of the register land in lanes from addr upward.
                    case (addr_lo)
                        2'd0:    dsram_wen = 4'b1111;
                        2'd1:    dsram_wen = 4'b1110;
                        2'd2:    dsram_wen = 4'b1100;
                        default: dsram_wen = 4'b1000;
                    endcase
                    dsram_wdata = in_store_data << {addr_lo, 3'b000};
                end
                default: begin
                    dsram_wen   = 4'b0000;
                    dsram_wdata = in_store_data;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // EXE->MEM pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex2mem_valid      <= 1'b0;
            ex2mem_result     <= '0;
            ex2mem_pc         <= '0;
            ex2mem_target_reg <= '0;
            ex2mem_rf_wen     <= 1'b0;
            ex2mem_ls_mode    <= '0;
            ex2mem_addr_lo    <= '0;
        end else if (mem_allowin) begin
            ex2mem_valid      <= in_valid;
            ex2mem_result     <= alu_result;
            ex2mem_pc         <= in_pc;
            ex2mem_target_reg <= in_target_reg;
            ex2mem_rf_wen     <= in_valid & rf_wen_eff;
            ex2mem_ls_mode    <= in_ls_mode;
            ex2mem_addr_lo    <= addr_lo;
        end
    end

`ifdef MYCPU_EXE_OVF_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex2mem_ovf <= 1'b0;
        end else if (mem_allowin) begin
            ex2mem_ovf <= in_valid & ovf;
        end
    end
`endif

endmodule

// File: tb/tb_mycpu_exe_stage.sv
module tb_mycpu_exe_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [31:0] in_pc;
    logic [4:0]  in_target_reg;
    logic [31:0] in_store_data;
    logic [3:0]  in_alu_op;
    logic        in_rf_wen;
    logic [5:0]  in_ls_mode;
    logic        exe_allowin;
    logic        mem_allowin;
    logic [5:0]  fwd_target;
    logic [31:0] fwd_data;
    logic        dsram_en;
    logic [3:0]  dsram_wen;
    logic [31:0] dsram_addr;
    logic [31:0] dsram_wdata;
    logic        ex2mem_valid;
    logic [31:0] ex2mem_result;
    logic [31:0] ex2mem_pc;
    logic [4:0]  ex2mem_target_reg;
    logic        ex2mem_rf_wen;
    logic [5:0]  ex2mem_ls_mode;
    logic [1:0]  ex2mem_addr_lo;
`ifdef MYCPU_EXE_OVF_TRAP_EN
    logic        ex2mem_ovf;
`endif

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    mycpu_exe_stage dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_op1            (in_op1),
        .in_op2            (in_op2),
        .in_pc             (in_pc),
        .in_target_reg     (in_target_reg),
        .in_store_data     (in_store_data),
        .in_alu_op         (in_alu_op),
        .in_rf_wen         (in_rf_wen),
        .in_ls_mode        (in_ls_mode),
        .exe_allowin       (exe_allowin),
        .mem_allowin       (mem_allowin),
        .fwd_target        (fwd_target),
        .fwd_data          (fwd_data),
        .dsram_en          (dsram_en),
        .dsram_wen         (dsram_wen),
        .dsram_addr        (dsram_addr),
        .dsram_wdata       (dsram_wdata),
        .ex2mem_valid      (ex2mem_valid),
        .ex2mem_result     (ex2mem_result),
        .ex2mem_pc         (ex2mem_pc),
        .ex2mem_target_reg (ex2mem_target_reg),
        .ex2mem_rf_wen     (ex2mem_rf_wen),
        .ex2mem_ls_mode    (ex2mem_ls_mode),
`ifdef MYCPU_EXE_OVF_TRAP_EN
        .ex2mem_addr_lo    (ex2mem_addr_lo),
        .ex2mem_ovf        (ex2mem_ovf)
`else
        .ex2mem_addr_lo    (ex2mem_addr_lo)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tgt, input logic wen,
                         input logic [5:0] ls, input logic [31:0] sd, input logic [31:0] pc);
        in_valid      = v;
        in_alu_op     = op;
        in_op1        = a;
        in_op2        = b;
        in_target_reg = tgt;
        in_rf_wen     = wen;
        in_ls_mode    = ls;
        in_store_data = sd;
        in_pc         = pc;
    endtask

    initial begin
        rst         = 1'b1;
        mem_allowin = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 6'h00, 32'h0, 32'h0);

        // Reset: registers cleared while rst is high
        #1;
        check("rst_valid",  {31'b0, ex2mem_valid}, 32'h0);
        check("rst_result", ex2mem_result, 32'h0);
        check("rst_rfwen",  {31'b0, ex2mem_rf_wen}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("idle_valid",  {31'b0, ex2mem_valid}, 32'h0);
        check("idle_pc",     ex2mem_pc, 32'h0);
        check("idle_fwd",    {26'b0, fwd_target}, 32'h0);
        check("allowin_hi",  {31'b0, exe_allowin}, 32'h1);
        mem_allowin = 1'b0;
        #1;
        check("allowin_lo",  {31'b0, exe_allowin}, 32'h0);
        mem_allowin = 1'b1;
        #1;

        // SLTU / SLT
        drive(1'b1, 4'b0011, 32'hFFFF_FFFF, 32'h1, 5'd8, 1'b1, 6'h00, 32'h0, 32'h0000_0100);
        #1;
        check("sltu_fwd_tgt",  {26'b0, fwd_target}, 32'h08);
        check("sltu_fwd_data", fwd_data, 32'h0);
        step();
        check("sltu_result", ex2mem_result, 32'h0);
        check("sltu_valid",  {31'b0, ex2mem_valid}, 32'h1);
        check("sltu_rfwen",  {31'b0, ex2mem_rf_wen}, 32'h1);
        check("sltu_tgt",    {27'b0, ex2mem_target_reg}, 32'h8);
        check("sltu_pc",     ex2mem_pc, 32'h0000_0100);
        in_alu_op = 4'b0010;
        #1;
        check("slt_fwd_data", fwd_data, 32'h1);
        step();
        check("slt_result", ex2mem_result, 32'h1);

        // Shifts
        drive(1'b1, 4'b1011, 32'h4, 32'h8000_0000, 5'd9, 1'b1, 6'h00, 32'h0, 32'h0000_0104);
        #1;
        check("sra_fwd_data", fwd_data, 32'hF800_0000);
        step();
        check("sra_result", ex2mem_result, 32'hF800_0000);
        in_alu_op = 4'b1010;
        step();
        check("srl_result", ex2mem_result, 32'h0800_0000);
        in_alu_op = 4'b1000;
        in_op2    = 32'h0000_0003;
        #1;
        check("sll_fwd_data", fwd_data, 32'h0000_0030);
        in_alu_op = 4'b1001;
        #1;
        check("op1001_zero", fwd_data, 32'h0);
        in_alu_op = 4'b0111;
        in_op1    = 32'h0F0F_0000;
        in_op2    = 32'h0000_00F0;
        #1;
        check("nor_fwd_data", fwd_data, 32'hF0F0_FF0F);

        // r0 never forwards
        drive(1'b1, 4'b0000, 32'h5, 32'h6, 5'd0, 1'b1, 6'h00, 32'h0, 32'h0);
        #1;
        check("r0_fwd_tgt",  {26'b0, fwd_target}, 32'h0);
        check("r0_fwd_data", fwd_data, 32'h0);

        // SB at 0x1003
        drive(1'b1, 4'b0000, 32'h1000, 32'h3, 5'd0, 1'b0, 6'b010000, 32'h1122_3344, 32'h0000_0200);
        #1;
        check("sb_en",    {31'b0, dsram_en}, 32'h1);
        check("sb_wen",   {28'b0, dsram_wen}, 32'h8);
        check("sb_addr",  dsram_addr, 32'h0000_1000);
        check("sb_wdata", dsram_wdata, 32'h4444_4444);
        step();
        check("sb_addr_lo", {30'b0, ex2mem_addr_lo}, 32'h3);
        check("sb_ls_mode", {26'b0, ex2mem_ls_mode}, 32'h10);

        // SWL at a=1
        drive(1'b1, 4'b0000, 32'h1000, 32'h1, 5'd0, 1'b0, 6'b010110, 32'h1122_3344, 32'h0000_0204);
        #1;
        check("swl_wen",   {28'b0, dsram_wen}, 32'h3);
        check("swl_wdata", dsram_wdata, 32'h0000_1122);
        step();

        // SH at a=2
        drive(1'b1, 4'b0000, 32'h1000, 32'h2, 5'd0, 1'b0, 6'b010010, 32'h1122_3344, 32'h0000_0208);
        #1;
        check("sh_wen",   {28'b0, dsram_wen}, 32'hC);
        check("sh_wdata", dsram_wdata, 32'h3344_3344);

        // SWR at a=2; registered result 0x1002 is then held across the stall
        drive(1'b1, 4'b0000, 32'h1000, 32'h2, 5'd0, 1'b0, 6'b011000, 32'h1122_3344, 32'h0000_020C);
        #1;
        check("swr_wen",   {28'b0, dsram_wen}, 32'hC);
        check("swr_wdata", dsram_wdata, 32'h3344_0000);
        step();
        check("swr_result", ex2mem_result, 32'h0000_1002);

        // LW stalled by MEM for 3 cycles
        drive(1'b1, 4'b0000, 32'h2000, 32'h4, 5'd5, 1'b1, 6'b100100, 32'h0, 32'h0000_0210);
        mem_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (dsram_en) pulses++;
            check("lw_stall_en",     {31'b0, dsram_en}, 32'h0);
            check("lw_stall_fwd",    {26'b0, fwd_target}, 32'h25);
            check("lw_stall_result", ex2mem_result, 32'h0000_1002);
            check("lw_stall_pc",     ex2mem_pc, 32'h0000_020C);
            step();
        end
        mem_allowin = 1'b1;
        #1;
        if (dsram_en) pulses++;
        check("lw_rel_en",   {31'b0, dsram_en}, 32'h1);
        check("lw_rel_addr", dsram_addr, 32'h0000_2004);
        check("lw_rel_wen",  {28'b0, dsram_wen}, 32'h0);
        check("lw_rel_fwd",  {26'b0, fwd_target}, 32'h25);
        step();
        in_valid = 1'b0;
        #1;
        if (dsram_en) pulses++;
        check("lw_result",   ex2mem_result, 32'h0000_2004);
        check("lw_pc",       ex2mem_pc, 32'h0000_0210);
        check("lw_rfwen",    {31'b0, ex2mem_rf_wen}, 32'h1);
        check("lw_pulses",   pulses, 32'd1);

        // Trapping add overflow
        drive(1'b1, 4'b1100, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1, 6'h00, 32'h0, 32'h0000_0300);
        #1;
`ifdef MYCPU_EXE_OVF_TRAP_EN
        check("addo_fwd_tgt", {26'b0, fwd_target}, 32'h0);
        step();
        check("addo_ovf",    {31'b0, ex2mem_ovf}, 32'h1);
        check("addo_rfwen",  {31'b0, ex2mem_rf_wen}, 32'h0);
        in_alu_op = 4'b1101;
        in_op1    = 32'h8000_0000;
        #1;
        check("subo_fwd_tgt", {26'b0, fwd_target}, 32'h0);
        step();
        check("subo_ovf",    {31'b0, ex2mem_ovf}, 32'h1);
        in_op1 = 32'h5;
        step();
        check("sub_noovf",   {31'b0, ex2mem_ovf}, 32'h0);
        check("sub_rfwen",   {31'b0, ex2mem_rf_wen}, 32'h1);
`else
        check("addo_fwd_tgt",  {26'b0, fwd_target}, 32'h03);
        check("addo_fwd_data", fwd_data, 32'h8000_0000);
        step();
        check("addo_result", ex2mem_result, 32'h8000_0000);
        check("addo_rfwen",  {31'b0, ex2mem_rf_wen}, 32'h1);
        in_alu_op = 4'b1101;
        in_op1    = 32'h8000_0000;
        step();
        check("subo_result", ex2mem_result, 32'h7FFF_FFFF);
`endif

        // Asynchronous reset in the middle of a stall
        mem_allowin = 1'b0;
        in_ls_mode  = 6'b100100;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid",  {31'b0, ex2mem_valid}, 32'h0);
        check("arst_result", ex2mem_result, 32'h0);
        check("arst_en",     {31'b0, dsram_en}, 32'h0);
        mem_allowin = 1'b1;
        #1;
        check("arst_en_follow", {31'b0, dsram_en}, 32'h1);
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mycpu_exe_stage.md
Name: mycpu_exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the ID→EXE pipeline-register bundle and evaluates the 4-bit ALU operation.
- Issues the data-SRAM request for loads and stores.
- Registers the result into the EXE→MEM pipeline register, under a valid/allow-in handshake with MEM.
- Drives the "minus-1 instruction" hazard/forward feedback back to decode.

Parameters:
- DW, 32, datapath width; only 32 is supported.
- RW, 5, register-index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  ID→EXE bundle holds a real instruction
- in_op1  in  32  operand A (rs, pc or zero-extended shamt)
- in_op2  in  32  operand B (rt or immediate)
- in_pc  in  32  instruction pc
- in_target_reg  in  5  destination register
- in_store_data  in  32  rt content for stores
- in_alu_op  in  4  ALU operation code
- in_rf_wen  in  1  instruction writes the register file
- in_ls_mode  in  6  [5]=load, [4]=store, [3:1]=size, [0]=sign-extend
- exe_allowin  out  1  EXE accepts a new bundle this cycle
- mem_allowin  in  1  MEM accepts the EXE→MEM register this cycle
- fwd_target  out  6  {is_load, target_reg} of the instruction in EXE
- fwd_data  out  32  ALU result of the instruction in EXE
- dsram_en  out  1  data SRAM request
- dsram_wen  out  4  byte write enables
- dsram_addr  out  32  word-aligned address
- dsram_wdata  out  32  lane-replicated store data
- ex2mem_valid  out  1  EXE→MEM register valid
- ex2mem_result  out  32  registered ALU result / effective address
- ex2mem_pc  out  32  registered pc
- ex2mem_target_reg  out  5  registered destination register
- ex2mem_rf_wen  out  1  registered write enable (qualified by valid)
- ex2mem_ls_mode  out  6  registered load/store mode
- ex2mem_addr_lo  out  2  registered effective-address bits [1:0]

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk, rising edge. While rst is high, every ex2mem_* output is 0.
- ALU, combinational on in_* (A=in_op1, B=in_op2):
  - 0000: A+B, wrapping.
  - 0001: A−B, wrapping.
  - 0010: signed A<B → 1, else 0.
  - 0011: unsigned A<B → 1, else 0.
  - 0100: A&B. 0101: A|B. 0110: A^B. 0111: ~(A|B).
  - 1000: B<<A[4:0].
  - 1010: B>>A[4:0], logical.
  - 1011: B>>>A[4:0], arithmetic.
  - 1100: A+B. 1101: A−B.
  - 1001, 1110, 1111: result 0.
- Effective address: the ALU result when ls_mode[5] or ls_mode[4] is set.
- Handshake:
  - exe_allowin = mem_allowin.
  - On a posedge with mem_allowin=1: the EXE→MEM register loads all in_* derived fields; ex2mem_valid <= in_valid.
  - With mem_allowin=0: the EXE→MEM register holds every field.
  - Latency is one cycle from in_* to ex2mem_*.
- SRAM request:
  - dsram_en = in_valid & mem_allowin & (ls_mode[5] | ls_mode[4]).
  - A request is issued exactly once per instruction, never while MEM stalls.
  - dsram_addr = {addr[31:2], 2'b00}.
- Store enables (ls_mode[4]=1; a = addr[1:0]); loads drive dsram_wen = 0000:
  - byte (000): 0001<<a; wdata = {4{data[7:0]}}.
  - half (001): a[1] ? 1100 : 0011; wdata = {2{data[15:0]}}.
  - word (010): 1111; wdata = data.
  - SWL (011): a=0→0001, 1→0011, 2→0111, 3→1111; wdata = data >> 8*(3−a).
  - SWR (100): a=0→1111, 1→1110, 2→1100, 3→1000; wdata = data << 8*a.
- Misalignment: misaligned half/word accesses are not checked; low bits are dropped.
- Forwarding:
  - Case in_valid & in_rf_wen & target≠0: fwd_target = {ls_mode[5], in_target_reg}; fwd_data = ALU result.
  - Otherwise: fwd_target = 6'b000000, fwd_data = 0. This means an r0 match always forwards 0.
  - fwd_* remain driven while MEM stalls.
- ex2mem_rf_wen = registered (in_valid & in_rf_wen).
- Reset mid-stall: all registers are cleared immediately; no pending request survives; dsram_en follows the inputs.

Optional Feature:
- Macro: MYCPU_EXE_OVF_TRAP_EN.
- Defined:
  - Ops 1100/1101 detect signed overflow. For add: A,B same sign and result sign differs. For sub: A,B sign differ and result sign ≠ A sign.
  - On overflow: register-file write and forwarding are suppressed (fwd_target = 0).
  - Extra output ex2mem_ovf (1 bit) is registered, reset 0.
- Undefined: 1100/1101 behave as 0000/0001; there is no ex2mem_ovf port.

Test Plan:
- Reset then release, in_valid=0 → all ex2mem_* 0; exe_allowin follows mem_allowin; fwd_target=0.
- alu_op=0011, A=0xFFFFFFFF, B=1, target=8, rf_wen=1 → next cycle ex2mem_result=0; in the same cycle as input, fwd_target=0x08; alu_op=0010 with the same operands gives 1.
- alu_op=1011, A=4, B=0x80000000 → 0xF8000000; alu_op=1010 with the same operands → 0x08000000.
- SB with A=0x1000, B=3, data=0x11223344 → dsram_en=1, wen=1000, addr=0x1000, wdata=0x44444444. SWL at a=1 → wen=0011, wdata=0x00001122.
- LW with mem_allowin=0 for 3 cycles then 1 → dsram_en=0 during the stall, exactly one pulse on release; fwd_target=0x20|target throughout; ex2mem_* hold during the stall.
- With MYCPU_EXE_OVF_TRAP_EN: op 1100, A=0x7FFFFFFF, B=1 → ex2mem_ovf=1, ex2mem_rf_wen=0, fwd_target=0. Without the macro → result 0x80000000 and rf_wen=1.
